// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice: unit indices, unit state
// encodings and the modulo pointer increment.
package cdb_arbiter_pkg;

  localparam int U_ADD = 0;
  localparam int U_MUL = 1;
  localparam int U_DIV = 2;
  localparam int U_LD  = 3;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_WORKING = 1'b1
  } unit_state_e;

  // Explicit wrap so a non-power-of-two unit count never yields an index >= n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin pick: first requesting index at or after ptr, scanning modulo
// NREQ. Pure combinational function of the request vector and the pointer.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic            any_grant
);

  logic [PW-1:0] idx_s;
  logic          hit_s;
  int            pos_s;

  // Scan from the pointer; the first hit locks out every later candidate.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    pos_s     = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s        = int'(ptr) + k;
      pos_s        = (pos_s >= NREQ) ? (pos_s - NREQ) : pos_s;
      idx_s        = PW'(pos_s);
      hit_s        = !any_grant && req_valid[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      winner       = hit_s ? idx_s : winner;
      any_grant    = any_grant | hit_s;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: combinational round-robin accept to the functional
// units, registered one-cycle broadcast of the accepted result.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        reqValid,
  input  logic [NREQ*DATA_W-1:0] reqData,
  input  logic [NREQ*TAG_W-1:0]  reqTag,
  output logic [NREQ-1:0]        resultAC,
  output logic                   cdbValid,
  output logic [DATA_W-1:0]      cdbData,
  output logic [TAG_W-1:0]       cdbTag,
  output logic [PW-1:0]          cdbSrc
);

  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     winner_s;
  logic [PW-1:0]     ptr_next_s;
  logic [NREQ-1:0]   grant_s;
  logic              any_s;
  logic [DATA_W-1:0] win_data_s;
  logic [TAG_W-1:0]  win_tag_s;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_valid (reqValid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .winner    (winner_s),
    .any_grant (any_s)
  );

  // Accept is suppressed while reset is held so no unit retires into a dead bus.
  assign resultAC   = nRST ? grant_s : '0;
  assign ptr_next_s = PW'(wrap_inc(int'(winner_s), NREQ));

  // One-hot AND-OR mux keeps data/tag out of the accept path.
  always_comb begin
    win_data_s = '0;
    win_tag_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_data_s = win_data_s | (grant_s[i] ? reqData[i*DATA_W +: DATA_W] : '0);
      win_tag_s  = win_tag_s  | (grant_s[i] ? reqTag[i*TAG_W +: TAG_W]    : '0);
    end
  end

  // Pointer and broadcast registers; payload holds on idle cycles.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr_r    <= '0;
      cdbValid <= 1'b0;
      cdbData  <= '0;
      cdbTag   <= '0;
      cdbSrc   <= '0;
    end else if (any_s) begin
      ptr_r    <= ptr_next_s;
      cdbValid <= 1'b1;
      cdbData  <= win_data_s;
      cdbTag   <= win_tag_s;
      cdbSrc   <= winner_s;
    end else begin
      cdbValid <= 1'b0;
    end
  end

endmodule
